// File: rtl/econet_rx_frame_queue_if.sv
// Receiver-side bus of econet_rx_frame_queue: byte stream in, RAM write port and
// descriptor-queue head out.
interface econet_rx_frame_queue_if #(
  parameter int unsigned BUF_AW  = 9,
  parameter int unsigned DESC_AW = 2
);
  logic [7:0]        rx_byte;
  logic              rx_byte_ready;
  logic              rx_frame_start;
  logic              rx_frame_end;
  logic [15:0]       rx_fcs;
  logic [15:0]       our_address;
  logic              desc_pop;
  logic              buf_wr_en;
  logic [BUF_AW-1:0] buf_wr_addr;
  logic [7:0]        buf_wr_data;
  logic              desc_valid;
  logic [BUF_AW-1:0] desc_start;
  logic [BUF_AW-1:0] desc_end;
  logic [BUF_AW-1:0] desc_count;
  logic [31:0]       desc_address;
  logic [15:0]       desc_scout;
  logic [DESC_AW:0]  desc_level;
  logic [7:0]        drop_count;

  modport slave (
    input  rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs, our_address, desc_pop,
    output buf_wr_en, buf_wr_addr, buf_wr_data, desc_valid, desc_start, desc_end, desc_count,
           desc_address, desc_scout, desc_level, drop_count
  );

  modport master (
    output rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs, our_address, desc_pop,
    input  buf_wr_en, buf_wr_addr, buf_wr_data, desc_valid, desc_start, desc_end, desc_count,
           desc_address, desc_scout, desc_level, drop_count
  );
endinterface

// File: rtl/econet_rx_frame_queue.sv
// Econet receive front end: writes frames into a circular byte RAM and queues descriptors.
// Define ECONET_RX_BROADCAST_EN to also accept frames addressed to 16'hFFFF.
module econet_rx_frame_queue #(
  parameter int unsigned BUF_AW    = 9,
  parameter int unsigned DESC_AW   = 2,
  parameter int unsigned HDR_BYTES = 6,
  parameter logic [15:0] FCS_GOOD  = 16'hF0B8
) (
  input logic                     econet_clk,
  input logic                     valid_rst,
  econet_rx_frame_queue_if.slave  bus_io
);
  localparam int unsigned DescDepth = 1 << DESC_AW;

  typedef logic [BUF_AW-1:0] addr_t;
  typedef logic [DESC_AW:0]  lvl_t;

  localparam addr_t AddrOne  = addr_t'(1);
  localparam addr_t HdrCnt   = addr_t'(HDR_BYTES);
  localparam lvl_t  LvlOne   = lvl_t'(1);
  localparam lvl_t  LvlFull  = lvl_t'(DescDepth);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StHdr     = 2'd1;
  localparam logic [1:0] StBody    = 2'd2;
  localparam logic [1:0] StDiscard = 2'd3;

  logic [1:0] state_q, state_d;
  addr_t      wr_ptr_q, wr_ptr_d;
  addr_t      frame_base_q, frame_base_d;
  addr_t      byte_cnt_q, byte_cnt_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] hdr_q [HDR_BYTES];
  lvl_t       head_q, tail_q, level;

  addr_t       q_start_q [DescDepth];
  addr_t       q_end_q   [DescDepth];
  addr_t       q_count_q [DescDepth];
  logic [31:0] q_addr_q  [DescDepth];
  logic [15:0] q_scout_q [DescDepth];

  logic [DESC_AW-1:0] head_idx, tail_idx;
  logic in_frame, empty, full, overflow, byte_in, wr_en;
  logic addr_ok, accept, push_en, pop_en;

  assign head_idx = head_q[DESC_AW-1:0];
  assign tail_idx = tail_q[DESC_AW-1:0];
  assign level    = tail_q - head_q;
  assign empty    = (level == '0);
  assign full     = (level == LvlFull);
  assign in_frame = (state_q == StHdr) || (state_q == StBody);

  // Start and end markers take priority over a byte in the same cycle.
  assign byte_in  = in_frame && bus_io.rx_byte_ready && !bus_io.rx_frame_start &&
                    !bus_io.rx_frame_end;
  assign overflow = (!empty && ((wr_ptr_q + AddrOne) == q_start_q[head_idx])) ||
                    (byte_cnt_q == '1);
  assign wr_en    = byte_in && !overflow;

`ifdef ECONET_RX_BROADCAST_EN
  assign addr_ok = ({hdr_q[1], hdr_q[0]} == bus_io.our_address) ||
                   ({hdr_q[1], hdr_q[0]} == 16'hFFFF);
`else
  assign addr_ok = ({hdr_q[1], hdr_q[0]} == bus_io.our_address);
`endif

  assign accept  = in_frame && bus_io.rx_frame_end && !bus_io.rx_frame_start &&
                   (bus_io.rx_fcs == FCS_GOOD) && (byte_cnt_q >= HdrCnt) && addr_ok;
  assign pop_en  = bus_io.desc_pop && !empty;
  assign push_en = accept && (!full || pop_en);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    frame_base_d = frame_base_q;
    byte_cnt_d   = byte_cnt_q;
    drop_d       = drop_q;
    if (bus_io.rx_frame_start) begin
      if (state_q == StIdle) frame_base_d = wr_ptr_q;
      else                   wr_ptr_d     = frame_base_q;
      state_d    = StHdr;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHdr, StBody: begin
          if (bus_io.rx_frame_end) begin
            state_d = StIdle;
            if (!push_en) wr_ptr_d = frame_base_q;
            if (accept && !push_en && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else if (byte_in) begin
            if (overflow) begin
              state_d  = StDiscard;
              wr_ptr_d = frame_base_q;
            end else begin
              wr_ptr_d   = wr_ptr_q + AddrOne;
              byte_cnt_d = byte_cnt_q + AddrOne;
              if (state_q == StHdr && (byte_cnt_q + AddrOne) == HdrCnt) state_d = StBody;
            end
          end
        end
        StDiscard: begin
          // Only an overflow leads here, so the frame is counted as dropped.
          if (bus_io.rx_frame_end) begin
            state_d = StIdle;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      frame_base_q <= '0;
      byte_cnt_q   <= '0;
      drop_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      for (int i = 0; i < int'(HDR_BYTES); i++) hdr_q[i] <= '0;
      for (int i = 0; i < int'(DescDepth); i++) begin
        q_start_q[i] <= '0;
        q_end_q[i]   <= '0;
        q_count_q[i] <= '0;
        q_addr_q[i]  <= '0;
        q_scout_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_base_q <= frame_base_d;
      byte_cnt_q   <= byte_cnt_d;
      drop_q       <= drop_d;
      for (int i = 0; i < int'(HDR_BYTES); i++) begin
        if (wr_en && byte_cnt_q == addr_t'(i)) hdr_q[i] <= bus_io.rx_byte;
      end
      if (push_en) begin
        q_start_q[tail_idx] <= frame_base_q;
        q_end_q[tail_idx]   <= wr_ptr_q;
        q_count_q[tail_idx] <= byte_cnt_q;
        q_addr_q[tail_idx]  <= {hdr_q[3], hdr_q[2], hdr_q[1], hdr_q[0]};
        q_scout_q[tail_idx] <= {hdr_q[4], hdr_q[5]};
        tail_q              <= tail_q + LvlOne;
      end
      if (pop_en) head_q <= head_q + LvlOne;
    end
  end

  assign bus_io.buf_wr_en    = wr_en;
  assign bus_io.buf_wr_addr  = wr_ptr_q;
  assign bus_io.buf_wr_data  = wr_en ? bus_io.rx_byte : 8'h00;
  assign bus_io.desc_valid   = !empty;
  assign bus_io.desc_start   = q_start_q[head_idx];
  assign bus_io.desc_end     = q_end_q[head_idx];
  assign bus_io.desc_count   = q_count_q[head_idx];
  assign bus_io.desc_address = q_addr_q[head_idx];
  assign bus_io.desc_scout   = q_scout_q[head_idx];
  assign bus_io.desc_level   = level;
  assign bus_io.drop_count   = drop_q;
endmodule

// File: tb/tb_econet_rx_frame_queue.sv
// Directed bench for econet_rx_frame_queue: a BUF_AW=9 instance for most steps and a
// BUF_AW=6 instance (held in reset until its step) for buffer-full wrap behaviour.
module tb_econet_rx_frame_queue;
  logic        econet_clk = 1'b0;
  logic        valid_rst, rst6;
  logic [7:0]  rx_byte;
  logic        rx_byte_ready, rx_frame_start, rx_frame_end, desc_pop;
  logic [15:0] rx_fcs, our_address;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt, wr6_cnt;
  logic [31:0] wr_first, wr_last, wr6_first, wr6_last;
  logic [31:0] exp_bc;

  always #5 econet_clk = ~econet_clk;

  econet_rx_frame_queue_if #(.BUF_AW(9), .DESC_AW(2)) bus ();
  econet_rx_frame_queue_if #(.BUF_AW(6), .DESC_AW(2)) bus6 ();

  assign bus.rx_byte         = rx_byte;
  assign bus.rx_byte_ready   = rx_byte_ready;
  assign bus.rx_frame_start  = rx_frame_start;
  assign bus.rx_frame_end    = rx_frame_end;
  assign bus.rx_fcs          = rx_fcs;
  assign bus.our_address     = our_address;
  assign bus.desc_pop        = desc_pop;
  assign bus6.rx_byte        = rx_byte;
  assign bus6.rx_byte_ready  = rx_byte_ready;
  assign bus6.rx_frame_start = rx_frame_start;
  assign bus6.rx_frame_end   = rx_frame_end;
  assign bus6.rx_fcs         = rx_fcs;
  assign bus6.our_address    = our_address;
  assign bus6.desc_pop       = desc_pop;

  econet_rx_frame_queue #(.BUF_AW(9), .DESC_AW(2)) dut (
    .econet_clk (econet_clk),
    .valid_rst  (valid_rst),
    .bus_io     (bus)
  );

  econet_rx_frame_queue #(.BUF_AW(6), .DESC_AW(2)) dut6 (
    .econet_clk (econet_clk),
    .valid_rst  (rst6),
    .bus_io     (bus6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge econet_clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_ready = 1'b1;
    #1;
    if (bus.buf_wr_en) begin
      if (wr_cnt == 0) wr_first = 32'(bus.buf_wr_addr);
      wr_last = 32'(bus.buf_wr_addr);
      wr_cnt++;
    end
    if (bus6.buf_wr_en) begin
      if (wr6_cnt == 0) wr6_first = 32'(bus6.buf_wr_addr);
      wr6_last = 32'(bus6.buf_wr_addr);
      wr6_cnt++;
    end
    tick();
    rx_byte_ready = 1'b0;
  endtask

  task automatic start_frame();
    wr_cnt         = 0;
    wr6_cnt        = 0;
    rx_frame_start = 1'b1;
    tick();
    rx_frame_start = 1'b0;
  endtask

  // Header: dst stn, dst net, src stn 10, src net 00, ctrl 80, port 99; then payload.
  task automatic send_frame(input logic [7:0] dstn, input logic [7:0] dnet, input int len);
    logic [7:0] b;
    start_frame();
    for (int i = 0; i < len; i++) begin
      case (i)
        0:       b = dstn;
        1:       b = dnet;
        2:       b = 8'h10;
        3:       b = 8'h00;
        4:       b = 8'h80;
        5:       b = 8'h99;
        default: b = 8'(i);
      endcase
      drive_byte(b);
    end
  endtask

  task automatic end_frame(input logic [15:0] fcs, input logic pop);
    rx_fcs       = fcs;
    rx_frame_end = 1'b1;
    desc_pop     = pop;
    tick();
    rx_frame_end = 1'b0;
    desc_pop     = 1'b0;
  endtask

  task automatic pop();
    desc_pop = 1'b1;
    tick();
    desc_pop = 1'b0;
  endtask

  initial begin
    valid_rst = 1'b1; rst6 = 1'b1;
    rx_byte = '0; rx_byte_ready = 0; rx_frame_start = 0; rx_frame_end = 0; desc_pop = 0;
    rx_fcs = '0; our_address = 16'h0102;
    wr_cnt = 0; wr6_cnt = 0; wr_first = '0; wr_last = '0; wr6_first = '0; wr6_last = '0;
`ifdef ECONET_RX_BROADCAST_EN
    exp_bc = 32'd1;
`else
    exp_bc = 32'd0;
`endif
    #12;
    check("rst_valid", 32'(bus.desc_valid), 32'd0);
    check("rst_level", 32'(bus.desc_level), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);
    check("rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
    check("rst_start", 32'(bus.desc_start), 32'd0);
    check("rst_addr", bus.desc_address, 32'd0);
    tick();
    valid_rst = 1'b0;

    // Single addressed frame
    send_frame(8'h02, 8'h01, 10);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd10);
    check("t1_wr_first", wr_first, 32'd0);
    check("t1_wr_last", wr_last, 32'd9);
    rx_fcs = 16'hF0B8; rx_frame_end = 1'b1;
    #1;
    check("t1_valid_at_end", 32'(bus.desc_valid), 32'd0);
    tick();
    rx_frame_end = 1'b0;
    check("t1_valid", 32'(bus.desc_valid), 32'd1);
    check("t1_start", 32'(bus.desc_start), 32'd0);
    check("t1_end", 32'(bus.desc_end), 32'd10);
    check("t1_count", 32'(bus.desc_count), 32'd10);
    check("t1_address", bus.desc_address, 32'h0010_0102);
    check("t1_scout", 32'(bus.desc_scout), 32'h8099);
    check("t1_level", 32'(bus.desc_level), 32'd1);

    // Fill the queue, then one more is dropped
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h02, 8'h01, 10);
      end_frame(16'hF0B8, 1'b0);
    end
    check("t2_level4", 32'(bus.desc_level), 32'd4);
    check("t2_drop0", 32'(bus.drop_count), 32'd0);
    send_frame(8'h02, 8'h01, 10);
    check("t2_5th_first", wr_first, 32'd40);
    end_frame(16'hF0B8, 1'b0);
    check("t2_level_full", 32'(bus.desc_level), 32'd4);
    check("t2_drop1", 32'(bus.drop_count), 32'd1);
    pop();
    check("t2_pop_level", 32'(bus.desc_level), 32'd3);
    check("t2_pop_start", 32'(bus.desc_start), 32'd10);
    send_frame(8'h02, 8'h01, 10);
    check("t2_6th_first", wr_first, 32'd40);
    end_frame(16'hF0B8, 1'b0);
    check("t2_6th_level", 32'(bus.desc_level), 32'd4);
    pop(); pop(); pop();
    check("t2_6th_start", 32'(bus.desc_start), 32'd40);
    check("t2_6th_end", 32'(bus.desc_end), 32'd50);
    pop();
    check("t2_empty", 32'(bus.desc_valid), 32'd0);

    // Rejections: bad FCS, wrong address, too short
    send_frame(8'h02, 8'h01, 10);
    end_frame(16'hF0B8, 1'b0);
    send_frame(8'h02, 8'h01, 10);
    end_frame(16'h1234, 1'b0);
    check("t3_badfcs_level", 32'(bus.desc_level), 32'd1);
    send_frame(8'h03, 8'h01, 10);
    end_frame(16'hF0B8, 1'b0);
    check("t3_badaddr_level", 32'(bus.desc_level), 32'd1);
    check("t3_drop", 32'(bus.drop_count), 32'd1);
    send_frame(8'h02, 8'h01, 10);
    check("t3_next_first", wr_first, 32'd60);
    end_frame(16'hF0B8, 1'b0);
    pop();
    check("t3_next_start", 32'(bus.desc_start), 32'd60);
    check("t3_next_end", 32'(bus.desc_end), 32'd70);
    pop();
    pop();
    check("t3_pop_empty_level", 32'(bus.desc_level), 32'd0);
    check("t3_pop_empty_valid", 32'(bus.desc_valid), 32'd0);
    send_frame(8'h02, 8'h01, 4);
    end_frame(16'hF0B8, 1'b0);
    check("t3_short_level", 32'(bus.desc_level), 32'd0);

    // Abort by a new opening flag
    send_frame(8'h02, 8'h01, 3);
    check("t5_abort_first", wr_first, 32'd70);
    send_frame(8'h02, 8'h01, 10);
    check("t5_new_first", wr_first, 32'd70);
    end_frame(16'hF0B8, 1'b0);
    check("t5_start", 32'(bus.desc_start), 32'd70);
    check("t5_end", 32'(bus.desc_end), 32'd80);
    pop();

    // Broadcast, then asynchronous reset mid-frame
    send_frame(8'hFF, 8'hFF, 10);
    end_frame(16'hF0B8, 1'b0);
    check("t6_bcast_level", 32'(bus.desc_level), exp_bc);
    send_frame(8'h02, 8'h01, 3);
    rx_byte = 8'h55; rx_byte_ready = 1'b1;
    #2;
    valid_rst = 1'b1;
    #1;
    check("t6_rst_drop", 32'(bus.drop_count), 32'd0);
    check("t6_rst_level", 32'(bus.desc_level), 32'd0);
    check("t6_rst_valid", 32'(bus.desc_valid), 32'd0);
    check("t6_rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
    tick();
    valid_rst = 1'b0; rx_byte_ready = 1'b0;

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h02, 8'h01, 10);
      if (i == 0) check("pp_first_after_rst", wr_first, 32'd0);
      end_frame(16'hF0B8, 1'b0);
    end
    send_frame(8'h02, 8'h01, 10);
    end_frame(16'hF0B8, 1'b1);
    check("pp_level", 32'(bus.desc_level), 32'd4);
    check("pp_drop", 32'(bus.drop_count), 32'd0);
    check("pp_head", 32'(bus.desc_start), 32'd10);
    pop(); pop(); pop();
    check("pp_last_start", 32'(bus.desc_start), 32'd40);

    // Small buffer: second frame would wrap onto the queued one
    rst6 = 1'b0;
    send_frame(8'h02, 8'h01, 40);
    end_frame(16'hF0B8, 1'b0);
    check("t4_level1", 32'(bus6.desc_level), 32'd1);
    check("t4_end1", 32'(bus6.desc_end), 32'd40);
    send_frame(8'h02, 8'h01, 40);
    check("t4_ovf_first", wr6_first, 32'd40);
    check("t4_ovf_cnt", 32'(wr6_cnt), 32'd23);
    check("t4_ovf_last", wr6_last, 32'd62);
    end_frame(16'hF0B8, 1'b0);
    check("t4_drop", 32'(bus6.drop_count), 32'd1);
    check("t4_level_after", 32'(bus6.desc_level), 32'd1);
    send_frame(8'h02, 8'h01, 10);
    check("t4_next_first", wr6_first, 32'd40);
    end_frame(16'hF0B8, 1'b0);
    check("t4_level2", 32'(bus6.desc_level), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
